// File: rtl/issueq_int.sv
// Integer issue queue: collapsing reservation station between dispatch and the integer ALU.
// Entries 0..count-1 are live with index 0 the oldest. Pending operands are resolved by
// snooping the CDB. The oldest entry with both operands ready is presented for issue.
module issueq_int #(
    parameter int DEPTH  = 4,
    parameter int W_TAG  = 6,
    parameter int W_DATA = 32,
    parameter int W_OP   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_en,
    output logic              dispatch_ready,
    input  logic [W_OP-1:0]   dispatch_opcode,
    input  logic [15:0]       dispatch_imm,
    input  logic [W_TAG-1:0]  dispatch_rdtag,
    input  logic [W_TAG-1:0]  dispatch_rstag,
    input  logic [W_TAG-1:0]  dispatch_rttag,
    input  logic [W_DATA-1:0] dispatch_rsdata,
    input  logic [W_DATA-1:0] dispatch_rtdata,
    input  logic              dispatch_rsvalid,
    input  logic              dispatch_rtvalid,
    input  logic [W_TAG-1:0]  cdb_tag,
    input  logic              cdb_valid,
    input  logic [W_DATA-1:0] cdb_data,
    output logic              issue_valid,
    input  logic              issue_grant,
    output logic [W_OP-1:0]   issue_opcode,
    output logic [15:0]       issue_imm,
    output logic [W_TAG-1:0]  issue_rdtag,
    output logic [W_DATA-1:0] issue_rsdata,
    output logic [W_DATA-1:0] issue_rtdata
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [CW-1:0]     count_q, count_n;
    logic [W_OP-1:0]   op_q     [DEPTH];
    logic [15:0]       imm_q    [DEPTH];
    logic [W_TAG-1:0]  rd_q     [DEPTH];
    logic [W_TAG-1:0]  rs_tag_q [DEPTH];
    logic [W_TAG-1:0]  rt_tag_q [DEPTH];
    logic [W_DATA-1:0] rs_data_q[DEPTH];
    logic [W_DATA-1:0] rt_data_q[DEPTH];
    logic              rs_v_q   [DEPTH];
    logic              rt_v_q   [DEPTH];

    logic [W_OP-1:0]   op_n     [DEPTH];
    logic [15:0]       imm_n    [DEPTH];
    logic [W_TAG-1:0]  rd_n     [DEPTH];
    logic [W_TAG-1:0]  rs_tag_n [DEPTH];
    logic [W_TAG-1:0]  rt_tag_n [DEPTH];
    logic [W_DATA-1:0] rs_data_n[DEPTH];
    logic [W_DATA-1:0] rt_data_n[DEPTH];
    logic              rs_v_n   [DEPTH];
    logic              rt_v_n   [DEPTH];

    logic [IW-1:0]     sel_idx;
    logic [CW-1:0]     wr_idx;
    logic              do_issue;
    logic              do_write;

    // Ready depends only on the registered occupancy, so a grant never reaches it.
    assign dispatch_ready = (count_q < CW'(DEPTH));
    assign do_issue       = issue_valid & issue_grant;
    assign do_write       = dispatch_en & dispatch_ready;
    assign wr_idx         = do_issue ? (count_q - 1'b1) : count_q;

    // Pick the lowest-index live entry whose operands are both present.
    always_comb begin
        sel_idx     = '0;
        issue_valid = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CW'(i) < count_q) && rs_v_q[i] && rt_v_q[i]) begin
                sel_idx     = IW'(i);
                issue_valid = 1'b1;
            end
        end
    end

    // Present the selected entry; everything reads zero when nothing is eligible.
    always_comb begin
        issue_opcode = '0;
        issue_imm    = '0;
        issue_rdtag  = '0;
        issue_rsdata = '0;
        issue_rtdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_valid && (sel_idx == IW'(i))) begin
                issue_opcode = op_q[i];
                issue_imm    = imm_q[i];
                issue_rdtag  = rd_q[i];
                issue_rsdata = rs_data_q[i];
                issue_rtdata = rt_data_q[i];
            end
        end
    end

    // Next queue image: collapse over the issued slot, snoop the CDB in post-shift
    // positions, then append the dispatched entry (with same-cycle CDB forwarding).
    always_comb begin
        op_n      = op_q;
        imm_n     = imm_q;
        rd_n      = rd_q;
        rs_tag_n  = rs_tag_q;
        rt_tag_n  = rt_tag_q;
        rs_data_n = rs_data_q;
        rt_data_n = rt_data_q;
        rs_v_n    = rs_v_q;
        rt_v_n    = rt_v_q;
        count_n   = count_q + CW'(do_write) - CW'(do_issue);

        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_issue && (IW'(i) >= sel_idx)) begin
                op_n[i]      = op_q[i+1];
                imm_n[i]     = imm_q[i+1];
                rd_n[i]      = rd_q[i+1];
                rs_tag_n[i]  = rs_tag_q[i+1];
                rt_tag_n[i]  = rt_tag_q[i+1];
                rs_data_n[i] = rs_data_q[i+1];
                rt_data_n[i] = rt_data_q[i+1];
                rs_v_n[i]    = rs_v_q[i+1];
                rt_v_n[i]    = rt_v_q[i+1];
            end
        end
        if (do_issue) begin
            rs_v_n[DEPTH-1] = 1'b0;
            rt_v_n[DEPTH-1] = 1'b0;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_valid && !rs_v_n[i] && (rs_tag_n[i] == cdb_tag)) begin
                rs_data_n[i] = cdb_data;
                rs_v_n[i]    = 1'b1;
            end
            if (cdb_valid && !rt_v_n[i] && (rt_tag_n[i] == cdb_tag)) begin
                rt_data_n[i] = cdb_data;
                rt_v_n[i]    = 1'b1;
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (do_write && (wr_idx == CW'(i))) begin
                op_n[i]     = dispatch_opcode;
                imm_n[i]    = dispatch_imm;
                rd_n[i]     = dispatch_rdtag;
                rs_tag_n[i] = dispatch_rstag;
                rt_tag_n[i] = dispatch_rttag;
                if (dispatch_rsvalid) begin
                    rs_data_n[i] = dispatch_rsdata;
                    rs_v_n[i]    = 1'b1;
                end else if (cdb_valid && (cdb_tag == dispatch_rstag)) begin
                    rs_data_n[i] = cdb_data;
                    rs_v_n[i]    = 1'b1;
                end else begin
                    rs_data_n[i] = dispatch_rsdata;
                    rs_v_n[i]    = 1'b0;
                end
                if (dispatch_rtvalid) begin
                    rt_data_n[i] = dispatch_rtdata;
                    rt_v_n[i]    = 1'b1;
                end else if (cdb_valid && (cdb_tag == dispatch_rttag)) begin
                    rt_data_n[i] = cdb_data;
                    rt_v_n[i]    = 1'b1;
                end else begin
                    rt_data_n[i] = dispatch_rtdata;
                    rt_v_n[i]    = 1'b0;
                end
            end
        end
    end

    // Queue state registers; reset empties the queue and clears every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]      <= '0;
                imm_q[i]     <= '0;
                rd_q[i]      <= '0;
                rs_tag_q[i]  <= '0;
                rt_tag_q[i]  <= '0;
                rs_data_q[i] <= '0;
                rt_data_q[i] <= '0;
                rs_v_q[i]    <= 1'b0;
                rt_v_q[i]    <= 1'b0;
            end
        end else begin
            count_q   <= count_n;
            op_q      <= op_n;
            imm_q     <= imm_n;
            rd_q      <= rd_n;
            rs_tag_q  <= rs_tag_n;
            rt_tag_q  <= rt_tag_n;
            rs_data_q <= rs_data_n;
            rt_data_q <= rt_data_n;
            rs_v_q    <= rs_v_n;
            rt_v_q    <= rt_v_n;
        end
    end

endmodule

// File: tb/tb_issueq_int.sv
// Self-checking bench for issueq_int: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_issueq_int;

    localparam int DEPTH  = 4;
    localparam int W_TAG  = 6;
    localparam int W_DATA = 32;
    localparam int W_OP   = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              dispatch_en = 1'b0;
    logic              dispatch_ready;
    logic [W_OP-1:0]   dispatch_opcode = '0;
    logic [15:0]       dispatch_imm = '0;
    logic [W_TAG-1:0]  dispatch_rdtag = '0;
    logic [W_TAG-1:0]  dispatch_rstag = '0;
    logic [W_TAG-1:0]  dispatch_rttag = '0;
    logic [W_DATA-1:0] dispatch_rsdata = '0;
    logic [W_DATA-1:0] dispatch_rtdata = '0;
    logic              dispatch_rsvalid = 1'b0;
    logic              dispatch_rtvalid = 1'b0;
    logic [W_TAG-1:0]  cdb_tag = '0;
    logic              cdb_valid = 1'b0;
    logic [W_DATA-1:0] cdb_data = '0;
    logic              issue_valid;
    logic              issue_grant = 1'b0;
    logic [W_OP-1:0]   issue_opcode;
    logic [15:0]       issue_imm;
    logic [W_TAG-1:0]  issue_rdtag;
    logic [W_DATA-1:0] issue_rsdata;
    logic [W_DATA-1:0] issue_rtdata;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [W_OP-1:0]   op;
        logic [15:0]       imm;
        logic [W_TAG-1:0]  rd;
        logic [W_TAG-1:0]  rst;
        logic [W_TAG-1:0]  rtt;
        logic [W_DATA-1:0] rsd;
        logic [W_DATA-1:0] rtd;
        bit                rsv;
        bit                rtv;
    } ent_t;

    ent_t model[$];

    issueq_int #(.DEPTH(DEPTH), .W_TAG(W_TAG), .W_DATA(W_DATA), .W_OP(W_OP)) dut (
        .clk              (clk),
        .reset            (reset),
        .dispatch_en      (dispatch_en),
        .dispatch_ready   (dispatch_ready),
        .dispatch_opcode  (dispatch_opcode),
        .dispatch_imm     (dispatch_imm),
        .dispatch_rdtag   (dispatch_rdtag),
        .dispatch_rstag   (dispatch_rstag),
        .dispatch_rttag   (dispatch_rttag),
        .dispatch_rsdata  (dispatch_rsdata),
        .dispatch_rtdata  (dispatch_rtdata),
        .dispatch_rsvalid (dispatch_rsvalid),
        .dispatch_rtvalid (dispatch_rtvalid),
        .cdb_tag          (cdb_tag),
        .cdb_valid        (cdb_valid),
        .cdb_data         (cdb_data),
        .issue_valid      (issue_valid),
        .issue_grant      (issue_grant),
        .issue_opcode     (issue_opcode),
        .issue_imm        (issue_imm),
        .issue_rdtag      (issue_rdtag),
        .issue_rsdata     (issue_rsdata),
        .issue_rtdata     (issue_rtdata)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs against the model, clock, then advance
    // the model. Entered and left at a falling edge (possibly a few ns after it).
    task automatic applyStimulus(
        input logic en, input logic [W_OP-1:0] op, input logic [15:0] imm,
        input logic [W_TAG-1:0] rd, input logic [W_TAG-1:0] rst, input logic [W_TAG-1:0] rtt,
        input logic [W_DATA-1:0] rsd, input logic [W_DATA-1:0] rtd,
        input logic rsv, input logic rtv, input logic grant,
        input logic cv, input logic [W_TAG-1:0] ct, input logic [W_DATA-1:0] cd);
        int   idx;
        bit   exp_valid;
        bit   exp_ready;
        ent_t e;
        idx       = -1;
        exp_ready = (model.size() < DEPTH);
        for (int k = 0; k < model.size(); k++) begin
            if (idx < 0 && model[k].rsv && model[k].rtv) idx = k;
        end
        exp_valid = (idx >= 0);

        dispatch_en      = en;
        dispatch_opcode  = op;
        dispatch_imm     = imm;
        dispatch_rdtag   = rd;
        dispatch_rstag   = rst;
        dispatch_rttag   = rtt;
        dispatch_rsdata  = rsd;
        dispatch_rtdata  = rtd;
        dispatch_rsvalid = rsv;
        dispatch_rtvalid = rtv;
        issue_grant      = grant;
        cdb_valid        = cv;
        cdb_tag          = ct;
        cdb_data         = cd;
        #1;
        checkOutput("ready", 64'(dispatch_ready), 64'(exp_ready));
        checkOutput("valid", 64'(issue_valid), 64'(exp_valid));
        checkOutput("opcode", 64'(issue_opcode), exp_valid ? 64'(model[idx].op)  : 64'd0);
        checkOutput("imm",    64'(issue_imm),    exp_valid ? 64'(model[idx].imm) : 64'd0);
        checkOutput("rdtag",  64'(issue_rdtag),  exp_valid ? 64'(model[idx].rd)  : 64'd0);
        checkOutput("rsdata", 64'(issue_rsdata), exp_valid ? 64'(model[idx].rsd) : 64'd0);
        checkOutput("rtdata", 64'(issue_rtdata), exp_valid ? 64'(model[idx].rtd) : 64'd0);

        @(posedge clk);
        if (exp_valid && grant) model.delete(idx);
        if (en && exp_ready) begin
            e = '{op: op, imm: imm, rd: rd, rst: rst, rtt: rtt,
                  rsd: rsd, rtd: rtd, rsv: rsv, rtv: rtv};
            model.push_back(e);
        end
        if (cv) begin
            for (int k = 0; k < model.size(); k++) begin
                if (!model[k].rsv && model[k].rst == ct) begin
                    model[k].rsd = cd;
                    model[k].rsv = 1'b1;
                end
                if (!model[k].rtv && model[k].rtt == ct) begin
                    model[k].rtd = cd;
                    model[k].rtv = 1'b1;
                end
            end
        end
        @(negedge clk);
        dispatch_en = 1'b0;
        issue_grant = 1'b0;
        cdb_valid   = 1'b0;
    endtask

    task automatic idleCycle(input logic grant);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, grant, 1'b0, '0, '0);
    endtask

    task automatic dispatchReady(input logic [W_DATA-1:0] rsd, input logic [W_DATA-1:0] rtd,
                                 input logic grant);
        applyStimulus(1'b1, 6'h20, 16'h1234, 6'd3, '0, '0, rsd, rtd, 1'b1, 1'b1, grant,
                      1'b0, '0, '0);
    endtask

    // Pull reset low between edges and confirm the outputs clear without a clock.
    task automatic resetCheck(input string tag);
        reset = 1'b0;
        #1;
        checkOutput({tag, "_ready"}, 64'(dispatch_ready), 64'd1);
        checkOutput({tag, "_valid"}, 64'(issue_valid), 64'd0);
        checkOutput({tag, "_rs"}, 64'(issue_rsdata), 64'd0);
        model.delete();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        checkOutput("rst_ready", 64'(dispatch_ready), 64'd1);
        checkOutput("rst_valid", 64'(issue_valid), 64'd0);

        // Both operands present: visible next cycle, granted, then empty.
        dispatchReady(32'd5, 32'd7, 1'b0);
        #1;
        checkOutput("t2_valid", 64'(issue_valid), 64'd1);
        checkOutput("t2_rs", 64'(issue_rsdata), 64'd5);
        checkOutput("t2_rt", 64'(issue_rtdata), 64'd7);
        idleCycle(1'b1);
        #1;
        checkOutput("t2_empty", 64'(issue_valid), 64'd0);

        // RS pending on tag 12, resolved by a later broadcast.
        applyStimulus(1'b1, 6'h21, 16'h0, 6'd4, 6'd12, '0, '0, 32'd1, 1'b0, 1'b1, 1'b0,
                      1'b0, '0, '0);
        idleCycle(1'b0);
        #1;
        checkOutput("t3_wait", 64'(issue_valid), 64'd0);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd12, 32'hDEAD);
        #1;
        checkOutput("t3_valid", 64'(issue_valid), 64'd1);
        checkOutput("t3_rs", 64'(issue_rsdata), 64'hDEAD);
        idleCycle(1'b1);

        // Broadcast in the dispatch cycle is forwarded into the new entry.
        applyStimulus(1'b1, 6'h22, 16'h0, 6'd5, 6'd9, '0, '0, 32'd2, 1'b0, 1'b1, 1'b0,
                      1'b1, 6'd9, 32'h55);
        #1;
        checkOutput("t4_valid", 64'(issue_valid), 64'd1);
        checkOutput("t4_rs", 64'(issue_rsdata), 64'h55);
        idleCycle(1'b1);

        // Fill with the oldest entry pending; younger ready entries issue around it.
        applyStimulus(1'b1, 6'h23, 16'h0, 6'd6, 6'd20, '0, '0, 32'd0, 1'b0, 1'b1, 1'b0,
                      1'b0, '0, '0);
        dispatchReady(32'h101, 32'd0, 1'b0);
        dispatchReady(32'h102, 32'd0, 1'b0);
        dispatchReady(32'h103, 32'd0, 1'b0);
        #1;
        checkOutput("t5_full", 64'(dispatch_ready), 64'd0);
        checkOutput("t5_first", 64'(issue_rsdata), 64'h101);
        idleCycle(1'b1);
        #1;
        checkOutput("t5_second", 64'(issue_rsdata), 64'h102);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd20, 32'h100);
        #1;
        checkOutput("t5_oldest", 64'(issue_rsdata), 64'h100);

        // Full queue: a dispatch alongside a grant is dropped, accepted the cycle after.
        dispatchReady(32'h104, 32'd0, 1'b0);
        dispatchReady(32'h105, 32'd0, 1'b1);
        #1;
        checkOutput("t6_ready", 64'(dispatch_ready), 64'd1);
        dispatchReady(32'h106, 32'd0, 1'b0);
        for (int k = 0; k < 5; k++) idleCycle(1'b1);
        #1;
        checkOutput("t6_drained", 64'(issue_valid), 64'd0);

        // Reset with three live entries.
        dispatchReady(32'd1, 32'd1, 1'b0);
        dispatchReady(32'd2, 32'd2, 1'b0);
        dispatchReady(32'd3, 32'd3, 1'b0);
        resetCheck("t1");

        // Randomized traffic with a small tag space so broadcasts hit often.
        for (int n = 0; n < 800; n++) begin
            applyStimulus(($urandom_range(0, 9) < 7), 6'($urandom), 16'($urandom),
                          6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                          6'($urandom_range(0, 7)), $urandom, $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
                          6'($urandom_range(0, 7)), $urandom);
            if (n == 400) resetCheck("rand_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        fails++;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
